// File: rtl/pid_cfg_loader.sv
// pid_cfg_loader
//   Transmit end of the PID core's strobe-latched configuration interface.
//   32-bit command words ([31:28] opcode, [27:0] payload) write shadow
//   registers.  COMMIT copies every shadow to the output registers in the
//   accept edge, then runs SETUP -> STROBE -> GAP.  This issues one clean
//   strobe pulse that pid_core latches on its rising edge.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   cmd_i           command word
//   cmd_valid_i     command present
//   cmd_ready_o     high in IDLE only; a command is taken on valid && ready
//   kp_o .. sp_o    signed S16_W parameter words to pid_core
//   alpha_o         EMA shift
//   decimate_o      decimation ratio (resets to all-ones)
//   enable_o        PID enable
//   strobe_o        latch strobe, direct flop output
//   busy_o          commit sequence in progress
//   err_o           sticky illegal-opcode flag, cleared by CLR_ERR
//   commit_cnt_o    completed commit sequences, wraps 255 -> 0
module pid_cfg_loader #(
   parameter int S16_W      = 16,
   parameter int DEC_W      = 14,
   parameter int STROBE_LEN = 4,
   parameter int GAP_LEN    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             cmd_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   output logic signed [S16_W-1:0] kp_o,
   output logic signed [S16_W-1:0] kd_o,
   output logic signed [S16_W-1:0] ki_o,
   output logic signed [S16_W-1:0] sp_o,
   output logic [3:0]              alpha_o,
   output logic [DEC_W-1:0]        decimate_o,
   output logic                    enable_o,
   output logic                    strobe_o,
   output logic                    busy_o,
   output logic                    err_o,
   output logic [7:0]              commit_cnt_o
);

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_KP     = 4'd1;
   localparam logic [3:0] OP_KD     = 4'd2;
   localparam logic [3:0] OP_KI     = 4'd3;
   localparam logic [3:0] OP_SP     = 4'd4;
   localparam logic [3:0] OP_ALPHA  = 4'd5;
   localparam logic [3:0] OP_DEC    = 4'd6;
   localparam logic [3:0] OP_EN     = 4'd7;
   localparam logic [3:0] OP_COMMIT = 4'd8;
   localparam logic [3:0] OP_CLRERR = 4'd9;

   // GAP counts GAP_LEN+1 states (see below), so the counter must reach GAP_LEN.
   localparam int CNT_MAX = (GAP_LEN > STROBE_LEN) ? GAP_LEN : STROBE_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // shadow registers
   logic [S16_W-1:0] kp_sh_q, kp_sh_d, kd_sh_q, kd_sh_d;
   logic [S16_W-1:0] ki_sh_q, ki_sh_d, sp_sh_q, sp_sh_d;
   logic [3:0]       alpha_sh_q, alpha_sh_d;
   logic [DEC_W-1:0] dec_sh_q, dec_sh_d;
   logic             en_sh_q, en_sh_d;

   // output registers
   logic [S16_W-1:0] kp_q, kp_d, kd_q, kd_d, ki_q, ki_d, sp_q, sp_d;
   logic [3:0]       alpha_q, alpha_d;
   logic [DEC_W-1:0] dec_q, dec_d;
   logic             en_q, en_d;
   logic             strobe_q, strobe_d;
   logic             err_q, err_d;
   logic [7:0]       commit_cnt_q, commit_cnt_d;

   logic        accept;
   logic [3:0]  opcode;
   logic [27:0] payload;

   assign opcode  = cmd_i[31:28];
   assign payload = cmd_i[27:0];
   assign accept  = cmd_valid_i && (state_q == ST_IDLE);

   // payload bits above the widest field carry no information
   logic unused_payload;
   assign unused_payload = ^payload[27:S16_W];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      kp_sh_d      = kp_sh_q;
      kd_sh_d      = kd_sh_q;
      ki_sh_d      = ki_sh_q;
      sp_sh_d      = sp_sh_q;
      alpha_sh_d   = alpha_sh_q;
      dec_sh_d     = dec_sh_q;
      en_sh_d      = en_sh_q;
      kp_d         = kp_q;
      kd_d         = kd_q;
      ki_d         = ki_q;
      sp_d         = sp_q;
      alpha_d      = alpha_q;
      dec_d        = dec_q;
      en_d         = en_q;
      err_d        = err_q;
      commit_cnt_d = commit_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (opcode)
                  OP_NOP:    ;
                  OP_KP:     kp_sh_d    = payload[S16_W-1:0];
                  OP_KD:     kd_sh_d    = payload[S16_W-1:0];
                  OP_KI:     ki_sh_d    = payload[S16_W-1:0];
                  OP_SP:     sp_sh_d    = payload[S16_W-1:0];
                  OP_ALPHA:  alpha_sh_d = payload[3:0];
                  OP_DEC:    dec_sh_d   = payload[DEC_W-1:0];
                  OP_EN:     en_sh_d    = payload[0];
                  OP_COMMIT: begin
                     kp_d    = kp_sh_q;
                     kd_d    = kd_sh_q;
                     ki_d    = ki_sh_q;
                     sp_d    = sp_sh_q;
                     alpha_d = alpha_sh_q;
                     dec_d   = dec_sh_q;
                     en_d    = en_sh_q;
                     cnt_d   = '0;
                     state_d = ST_SETUP;
                  end
                  OP_CLRERR: err_d = 1'b0;
                  default:   err_d = 1'b1;
               endcase
            end
         end
         ST_SETUP: begin
            cnt_d   = '0;
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            // strobe_o trails the state by one flop, so the first GAP cycle
            // still shows the pulse at the pin; hold one extra cycle to give
            // GAP_LEN low cycles before the next command can be taken.
            if (cnt_q == CNT_W'(GAP_LEN)) begin
               cnt_d        = '0;
               commit_cnt_d = commit_cnt_q + 8'd1;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // registered from the current state: glitch-free, and one extra setup cycle
   assign strobe_d = (state_q == ST_STROBE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         kp_sh_q      <= '0;
         kd_sh_q      <= '0;
         ki_sh_q      <= '0;
         sp_sh_q      <= '0;
         alpha_sh_q   <= '0;
         dec_sh_q     <= '1;
         en_sh_q      <= 1'b0;
         kp_q         <= '0;
         kd_q         <= '0;
         ki_q         <= '0;
         sp_q         <= '0;
         alpha_q      <= '0;
         dec_q        <= '1;
         en_q         <= 1'b0;
         strobe_q     <= 1'b0;
         err_q        <= 1'b0;
         commit_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         kp_sh_q      <= kp_sh_d;
         kd_sh_q      <= kd_sh_d;
         ki_sh_q      <= ki_sh_d;
         sp_sh_q      <= sp_sh_d;
         alpha_sh_q   <= alpha_sh_d;
         dec_sh_q     <= dec_sh_d;
         en_sh_q      <= en_sh_d;
         kp_q         <= kp_d;
         kd_q         <= kd_d;
         ki_q         <= ki_d;
         sp_q         <= sp_d;
         alpha_q      <= alpha_d;
         dec_q        <= dec_d;
         en_q         <= en_d;
         strobe_q     <= strobe_d;
         err_q        <= err_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign kp_o         = kp_q;
   assign kd_o         = kd_q;
   assign ki_o         = ki_q;
   assign sp_o         = sp_q;
   assign alpha_o      = alpha_q;
   assign decimate_o   = dec_q;
   assign enable_o     = en_q;
   assign strobe_o     = strobe_q;
   assign err_o        = err_q;
   assign commit_cnt_o = commit_cnt_q;

endmodule
